// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between icache and dcache.
// Latches the granted request and gates the memory response back to it.
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] icache_dfp_addr,
  input  logic                  icache_dfp_read,
  input  logic                  icache_dfp_write,
  input  logic [DATA_WIDTH-1:0] icache_dfp_wdata,
  output logic [DATA_WIDTH-1:0] icache_dfp_rdata,
  output logic                  icache_dfp_resp,
  input  logic [ADDR_WIDTH-1:0] dcache_dfp_addr,
  input  logic                  dcache_dfp_read,
  input  logic                  dcache_dfp_write,
  input  logic [DATA_WIDTH-1:0] dcache_dfp_wdata,
  output logic [DATA_WIDTH-1:0] dcache_dfp_rdata,
  output logic                  dcache_dfp_resp,
  output logic [ADDR_WIDTH-1:0] dfp_addr,
  output logic                  dfp_read,
  output logic                  dfp_write,
  output logic [DATA_WIDTH-1:0] dfp_wdata,
  input  logic [DATA_WIDTH-1:0] dfp_rdata,
  input  logic                  dfp_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;

  logic req_i;
  logic req_d;

  assign req_i = icache_dfp_read | icache_dfp_write;
  assign req_d = dcache_dfp_read | dcache_dfp_write;

  assign dfp_addr  = addr_q;
  assign dfp_wdata = wdata_q;
  assign dfp_read  = read_q;
  assign dfp_write = write_q;

  assign icache_dfp_rdata = dfp_rdata;
  assign dcache_dfp_rdata = dfp_rdata;

  // State and latched memory request; reset returns to IDLE with icache favoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      read_q   <= read_d;
      write_q  <= write_d;
    end
  end

  // Arbitrate in IDLE, hold the granted request, route resp to the owner.
  always_comb begin
    state_d         = state_q;
    last_d_d        = last_d_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    read_d          = read_q;
    write_d         = write_q;
    icache_dfp_resp = 1'b0;
    dcache_dfp_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i && (!req_d || last_d_q)) begin
          state_d  = GRANT_I;
          last_d_d = 1'b0;
          addr_d   = icache_dfp_addr;
          wdata_d  = icache_dfp_wdata;
          write_d  = icache_dfp_write;
          read_d   = icache_dfp_read & ~icache_dfp_write;
        end else if (req_d) begin
          state_d  = GRANT_D;
          last_d_d = 1'b1;
          addr_d   = dcache_dfp_addr;
          wdata_d  = dcache_dfp_wdata;
          write_d  = dcache_dfp_write;
          read_d   = dcache_dfp_read & ~dcache_dfp_write;
        end
      end
      GRANT_I: begin
        icache_dfp_resp = dfp_resp;
        if (dfp_resp) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = IDLE;
        end
      end
      GRANT_D: begin
        dcache_dfp_resp = dfp_resp;
        if (dfp_resp) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expected memory requests and
// upstream responses are queued by stimulus and checked by monitors.
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;

  typedef struct {
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            lat;
    int            gap;
  } mreq_t;

  typedef struct {
    logic          port;
    logic [DW-1:0] rdata;
  } uresp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] i_addr, d_addr;
  logic          i_rd, i_wr, d_rd, d_wr;
  logic [DW-1:0] i_wdata, d_wdata;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          i_resp, d_resp;
  logic [AW-1:0] m_addr;
  logic          m_rd, m_wr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_resp;

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .icache_dfp_addr  (i_addr),
    .icache_dfp_read  (i_rd),
    .icache_dfp_write (i_wr),
    .icache_dfp_wdata (i_wdata),
    .icache_dfp_rdata (i_rdata),
    .icache_dfp_resp  (i_resp),
    .dcache_dfp_addr  (d_addr),
    .dcache_dfp_read  (d_rd),
    .dcache_dfp_write (d_wr),
    .dcache_dfp_wdata (d_wdata),
    .dcache_dfp_rdata (d_rdata),
    .dcache_dfp_resp  (d_resp),
    .dfp_addr         (m_addr),
    .dfp_read         (m_rd),
    .dfp_write        (m_wr),
    .dfp_wdata        (m_wdata),
    .dfp_rdata        (m_rdata),
    .dfp_resp         (m_resp)
  );

  int     checks   = 0;
  int     failures = 0;
  mreq_t  memq[$];
  uresp_t upq[$];
  mreq_t  cur;
  int     cnt;
  int     idle;
  bit     busy;
  bit     spur;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  task automatic exp_mem(input logic [AW-1:0] a, input logic rd,
                         input logic wr, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rdat, input int lat,
                         input int gap);
    mreq_t m;
    m.addr = a; m.rd = rd; m.wr = wr; m.wdata = wd;
    m.rdata = rdat; m.lat = lat; m.gap = gap;
    memq.push_back(m);
  endtask

  task automatic exp_txn(input logic p, input logic [AW-1:0] a,
                         input logic rd, input logic wr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rdat,
                         input int lat, input int gap);
    uresp_t u;
    exp_mem(a, rd & ~wr, wr, wd, rdat, lat, gap);
    u.port = p; u.rdata = rdat;
    upq.push_back(u);
  endtask

  task automatic set_req(input logic p, input logic [AW-1:0] a,
                         input logic rd, input logic wr,
                         input logic [DW-1:0] wd);
    if (!p) begin
      i_addr = a; i_rd = rd; i_wr = wr; i_wdata = wd;
    end else begin
      d_addr = a; d_rd = rd; d_wr = wr; d_wdata = wd;
    end
  endtask

  task automatic drop(input logic p);
    if (!p) begin i_rd = 1'b0; i_wr = 1'b0; end
    else begin d_rd = 1'b0; d_wr = 1'b0; end
  endtask

  task automatic wait_resp(input logic p, input int scr);
    int n;
    bit got;
    n = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk); #2;
      if (p ? d_resp : i_resp) got = 1'b1;
      else begin
        n++;
        if (n == scr) begin
          if (!p) begin i_addr = 32'hFFFF_0000; i_wdata = 64'h0BAD_F00D_0BAD_F00D; end
          else begin d_addr = 32'hFFFF_0000; d_wdata = 64'h0BAD_F00D_0BAD_F00D; end
        end
      end
    end
    chk(p ? "d_resp_wait" : "i_resp_wait", got, 1);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // Memory model: checks each new request against the queue, holds it,
  // answers after the queued latency.
  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0; m_resp = 1'b0; idle = 0; cnt = 0; spur = 1'b0;
    end else if (m_resp) begin
      m_resp = 1'b0;
      busy = 1'b0;
      chk("rw_clear", {m_rd, m_wr}, 2'b00);
      idle = 1;
    end else if (!busy && (m_rd || m_wr)) begin
      chk("memq_nonempty", memq.size() != 0, 1);
      if (memq.size() != 0) cur = memq.pop_front();
      else begin cur.lat = 1; cur.gap = -1; cur.rdata = '0; end
      chk("req_addr", m_addr, cur.addr);
      chk("req_rw", {m_rd, m_wr}, {cur.rd, cur.wr});
      if (cur.wr) chk("req_wdata", m_wdata, cur.wdata);
      if (cur.gap >= 0) chk("turnaround", idle, cur.gap);
      cnt = cur.lat;
      busy = 1'b1;
    end else if (busy) begin
      chk("hold_addr", m_addr, cur.addr);
      chk("hold_rw", {m_rd, m_wr}, {cur.rd, cur.wr});
      if (cur.wr) chk("hold_wdata", m_wdata, cur.wdata);
      cnt--;
      if (cnt == 0) begin
        m_resp = 1'b1;
        m_rdata = cur.rdata;
      end
    end else begin
      idle++;
      if (spur) begin
        spur = 1'b0;
        m_resp = 1'b1;
        m_rdata = 64'hBADB_ADBA_DBAD_BADB;
      end
    end
  end

  // Upstream monitor: every resp must match the head of the response queue.
  always @(negedge clk) begin
    uresp_t e;
    #1;
    if (!rst && (i_resp || d_resp)) begin
      chk("resp_excl", i_resp & d_resp, 0);
      chk("upq_nonempty", upq.size() != 0, 1);
      if (upq.size() != 0) begin
        e = upq.pop_front();
        chk("resp_port", d_resp, e.port);
        chk("i_rdata", i_rdata, e.rdata);
        chk("d_rdata", d_rdata, e.rdata);
      end
    end
  end

  initial begin
    rst = 1'b1; spur = 1'b0;
    i_addr = '0; i_rd = 0; i_wr = 0; i_wdata = '0;
    d_addr = '0; d_rd = 0; d_wr = 0; d_wdata = '0;
    m_rdata = '0; m_resp = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_addr", m_addr, 0);
    chk("rst_wdata", m_wdata, 0);
    chk("rst_rw", {m_rd, m_wr}, 2'b00);
    chk("rst_resp", {i_resp, d_resp}, 2'b00);
    #1 rst = 1'b0;

    // single icache read
    exp_txn(0, 32'h0000_1040, 1, 0, 0, 64'hDEAD_BEEF_0123_4567, 5, -1);
    @(negedge clk); #2;
    set_req(0, 32'h0000_1040, 1, 0, 0);
    @(posedge clk); #1;
    chk("t1_lat_read", m_rd, 1);
    chk("t1_lat_addr", m_addr, 32'h0000_1040);
    wait_resp(0, 0);
    drop(0);
    repeat (3) @(negedge clk);

    // simultaneous from reset: icache first, then dcache write
    do_reset();
    exp_txn(0, 32'h100, 1, 0, 0, 64'h1111_2222_3333_4444, 3, -1);
    exp_txn(1, 32'h200, 0, 1, {16{4'hA}}, 64'h0, 4, 1);
    @(negedge clk); #2;
    set_req(0, 32'h100, 1, 0, 0);
    set_req(1, 32'h200, 0, 1, {16{4'hA}});
    fork
      begin wait_resp(0, 0); drop(0); end
      begin wait_resp(1, 0); drop(1); end
    join
    repeat (3) @(negedge clk);

    // both continuously requesting: I,D,I,D,I,D
    for (int k = 0; k < 3; k++) begin
      exp_txn(0, 32'h1000 + 32'(k * 64), 1, 0, 0, 64'h100 + 64'(k),
              2 + k, (k == 0) ? -1 : 1);
      exp_txn(1, 32'h2000 + 32'(k * 64), 0, 1, 64'hD0 + 64'(k), 64'h0,
              3, 1);
    end
    @(negedge clk); #2;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          set_req(0, 32'h1000 + 32'(k * 64), 1, 0, 0);
          wait_resp(0, 0);
        end
        drop(0);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          set_req(1, 32'h2000 + 32'(k * 64), 0, 1, 64'hD0 + 64'(k));
          wait_resp(1, 0);
        end
        drop(1);
      end
    join
    repeat (3) @(negedge clk);

    // dcache scrambles addr/wdata while granted
    exp_txn(1, 32'h300, 0, 1, 64'h5555_5555_5555_5555, 64'h0, 8, -1);
    @(negedge clk); #2;
    set_req(1, 32'h300, 0, 1, 64'h5555_5555_5555_5555);
    wait_resp(1, 3);
    drop(1);
    repeat (3) @(negedge clk);

    // spurious resp in IDLE, then a normal dcache read
    @(negedge clk); #2;
    spur = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    exp_txn(1, 32'h400, 1, 0, 0, 64'h4444_0000_4444_0000, 2, -1);
    set_req(1, 32'h400, 1, 0, 0);
    @(posedge clk); #1;
    chk("t5_lat_read", m_rd, 1);
    wait_resp(1, 0);
    drop(1);
    repeat (3) @(negedge clk);

    // reset two cycles into a granted read
    exp_mem(32'h500, 1, 0, 0, 64'h5, 10, -1);
    @(negedge clk); #2;
    set_req(0, 32'h500, 1, 0, 0);
    @(posedge clk); #1;
    chk("t6_granted", m_rd, 1);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    drop(0);
    @(posedge clk); #1;
    chk("t6_rst_read", m_rd, 0);
    @(negedge clk); #2;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    exp_txn(0, 32'h600, 1, 0, 0, 64'h6666_7777_8888_9999, 3, -1);
    set_req(0, 32'h600, 1, 0, 0);
    @(posedge clk); #1;
    chk("t6_new_read", m_rd, 1);
    chk("t6_new_addr", m_addr, 32'h600);
    wait_resp(0, 0);
    drop(0);
    repeat (5) @(negedge clk);

    chk("memq_drained", memq.size(), 0);
    chk("upq_drained", upq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
